if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage pipeline: owns the PC register, drives PC to IM,

---
 rtl/if_stage_if.sv | 39 +++
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if : bundle between the fetch stage and its surroundings
//   (hazard unit, ID stage, instruction memory).
//   master : environment side, drives control/redirect inputs and IM_OUT
//   slave  : fetch stage side, drives PC and the IF/ID register outputs
//   stall, flush_d          hazard control
//   npc_sel, br_target,
//   j_index, jr_target      next-PC selection decided in ID
//   IM_OUT / PC             instruction memory read port
//   instr_d, pc_d, pc8_d,
//   valid_d                 IF/ID register
//   addr_err, fetch_cnt     status
// ---------------------------------------------------------------------------
interface if_stage_if;
   logic        stall;
   logic        flush_d;
   logic [1:0]  npc_sel;
   logic [31:0] br_target;
   logic [25:0] j_index;
   logic [31:0] jr_target;
   logic [31:0] IM_OUT;
   logic [31:0] PC;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        addr_err;
   logic [31:0] fetch_cnt;

   modport master (
      output stall, flush_d, npc_sel, br_target, j_index, jr_target, IM_OUT,
      input  PC, instr_d, pc_d, pc8_d, valid_d, addr_err, fetch_cnt
   );

   modport slave (
      input  stall, flush_d, npc_sel, br_target, j_index, jr_target, IM_OUT,
      output PC, instr_d, pc_d, pc8_d, valid_d, addr_err, fetch_cnt
   );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage MIPS pipeline.
//   Owns the PC, selects the next PC (sequential / branch / j / jr), rejects
//   illegal targets and captures IM_OUT into the IF/ID register. The delay
//   slot instruction in F at redirect time is always kept.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset
//   bus    : if_stage_if.slave (controls, redirect targets, IM port, IF/ID)
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC       = 32'h0000_3000,
   parameter int unsigned IM_DEPTH_WORDS = 1024
) (
   input logic       clk,
   input logic       reset,
   if_stage_if.slave bus
);

   // One past the last legal byte address; 33 bits so the bound cannot wrap.
   localparam logic [32:0] PC_LIMIT = 33'(RESET_PC) + 33'(IM_DEPTH_WORDS) * 33'd4;

   logic [31:0] fpc_q,       fpc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q,    ifid_pc_d;
   logic [31:0] ifid_pc8_q,   ifid_pc8_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        addr_err_q,   addr_err_d;
   logic [31:0] fetch_cnt_q,  fetch_cnt_d;

   logic [31:0] npc;
   logic        npc_ok;

   // Next-PC selection; redirect selects are meaningless while ID holds a bubble.
   always_comb begin
      npc = fpc_q + 32'd4;
      if (ifid_valid_q) begin
         unique case (bus.npc_sel)
            2'b00: npc = fpc_q + 32'd4;
            2'b01: npc = bus.br_target;
            2'b10: npc = {ifid_pc_q[31:28], bus.j_index, 2'b00};
            2'b11: npc = bus.jr_target;
         endcase
      end
      npc_ok = (npc[1:0] == 2'b00) && (npc >= RESET_PC) && ({1'b0, npc} < PC_LIMIT);
   end

   always_comb begin
      fpc_d        = fpc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc8_d   = ifid_pc8_q;
      ifid_valid_d = ifid_valid_q;
      addr_err_d   = addr_err_q;
      fetch_cnt_d  = fetch_cnt_q;

      if (bus.stall) begin
         if (bus.flush_d) begin
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
         end
      end else if (!npc_ok) begin
         // Rejected target: PC stays put, ID gets a bubble, error is sticky.
         addr_err_d   = 1'b1;
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
      end else begin
         fpc_d = npc;
         if (bus.flush_d) begin
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
         end else begin
            ifid_instr_d = bus.IM_OUT;
            ifid_pc_d    = fpc_q;
            ifid_pc8_d   = fpc_q + 32'd8;
            ifid_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fpc_q        <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_pc8_q   <= 32'd8;
         ifid_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         fpc_q        <= fpc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc8_q   <= ifid_pc8_d;
         ifid_valid_q <= ifid_valid_d;
         addr_err_q   <= addr_err_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   assign bus.PC        = fpc_q;
   assign bus.instr_d   = ifid_instr_q;
   assign bus.pc_d      = ifid_pc_q;
   assign bus.pc8_d     = ifid_pc8_q;
   assign bus.valid_d   = ifid_valid_q;
   assign bus.addr_err  = addr_err_q;
   assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage. Directed pipeline scenarios
//   followed by randomized control/redirect traffic, each cycle compared
//   against a behavioural model of the fetch rules and a word-array IM.
// ---------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam int unsigned DEPTH  = 1024;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   if_stage_if bus ();

   if_stage #(.RESET_PC(RST_PC), .IM_DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] imem [DEPTH];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Instruction memory: combinational read at the DUT's PC.
   logic [31:0] im_idx;
   always_comb begin
      im_idx     = (bus.PC - RST_PC) >> 2;
      bus.IM_OUT = (im_idx < DEPTH) ? imem[im_idx[9:0]] : 32'hDEAD_BEEF;
   end

   // Reference state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc8, m_cnt;
   bit          m_valid, m_err;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit legal_addr(input logic [31:0] a);
      return (a % 4 == 0) && (64'(a) >= 64'(RST_PC)) && (64'(a) < 64'(RST_PC) + 64'(DEPTH) * 4);
   endfunction

   task automatic model_update(input bit rst_n, input bit st, input bit fl,
                               input logic [1:0] sel, input logic [31:0] br,
                               input logic [25:0] ji, input logic [31:0] jr);
      logic [31:0] target;
      if (!rst_n) begin
         m_pc = RST_PC; m_instr = 0; m_pcd = 0; m_pc8 = 8;
         m_valid = 0; m_err = 0; m_cnt = 0;
         return;
      end
      target = m_pc + 4;
      if (m_valid) begin
         if (sel == 1) target = br;
         if (sel == 2) target = {m_pcd[31:28], ji, 2'b00};
         if (sel == 3) target = jr;
      end
      if (st) begin
         if (fl) begin m_instr = 0; m_valid = 0; end
      end else if (!legal_addr(target)) begin
         m_err = 1; m_instr = 0; m_valid = 0;
      end else begin
         if (fl) begin
            m_instr = 0; m_valid = 0;
         end else begin
            m_instr = imem[(m_pc - RST_PC) / 4];
            m_pcd   = m_pc;
            m_pc8   = m_pc + 8;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
         end
         m_pc = target;
      end
   endtask

   // Called just after a falling edge: drive one cycle of inputs, let the
   // rising edge happen, then compare at the following falling edge.
   task automatic step(input bit rst_n, input bit st, input bit fl,
                       input logic [1:0] sel, input logic [31:0] br,
                       input logic [25:0] ji, input logic [31:0] jr);
      reset         = rst_n;
      bus.stall     = st;
      bus.flush_d   = fl;
      bus.npc_sel   = sel;
      bus.br_target = br;
      bus.j_index   = ji;
      bus.jr_target = jr;
      model_update(rst_n, st, fl, sel, br, ji, jr);
      @(negedge clk);
      check32("PC",        bus.PC,        m_pc);
      check32("instr_d",   bus.instr_d,   m_instr);
      check32("pc_d",      bus.pc_d,      m_pcd);
      check32("pc8_d",     bus.pc8_d,     m_pc8);
      check32("valid_d",   32'(bus.valid_d),  32'(m_valid));
      check32("addr_err",  32'(bus.addr_err), 32'(m_err));
      check32("fetch_cnt", bus.fetch_cnt, m_cnt);
   endtask

   task automatic seq();
      step(1, 0, 0, 2'b00, '0, '0, '0);
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = RST_PC + 4 * $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 7))
         0: t = t + 32'($urandom_range(1, 3));
         1: t = $urandom;
         default: ;
      endcase
      return t;
   endfunction

   initial begin
      foreach (imem[i]) imem[i] = $urandom;
      reset = 0; bus.stall = 0; bus.flush_d = 0; bus.npc_sel = 0;
      bus.br_target = 0; bus.j_index = 0; bus.jr_target = 0;
      m_pc = RST_PC; m_instr = 0; m_pcd = 0; m_pc8 = 8; m_valid = 0; m_err = 0; m_cnt = 0;
      @(negedge clk);

      // Reset held two cycles, then sequential fetch
      step(0, 1, 1, 2'b11, 32'h1, 26'h1, 32'h1);
      step(0, 0, 0, 2'b10, '0, '0, '0);
      check32("rst_pc8", bus.pc8_d, 32'h8);
      seq();
      check32("seq1_pc_d", bus.pc_d, 32'h3000);
      check32("seq1_pc8", bus.pc8_d, 32'h3008);
      check32("seq1_instr", bus.instr_d, imem[0]);
      seq();
      check32("seq2_PC", bus.PC, 32'h3008);

      // Stall 3 cycles at PC=0x3008
      repeat (3) step(1, 1, 0, 2'b00, '0, '0, '0);
      check32("stall_PC", bus.PC, 32'h3008);
      check32("stall_cnt", bus.fetch_cnt, 32'd2);

      // j in ID (pc_d=0x3004): delay slot 0x3008 loaded, target 0x3040
      step(1, 0, 0, 2'b10, '0, 26'h0C10, '0);
      check32("j_PC", bus.PC, 32'h3040);
      check32("j_slot_pc", bus.pc_d, 32'h3008);
      check32("j_valid", 32'(bus.valid_d), 32'd1);
      check32("j_cnt", bus.fetch_cnt, 32'd3);
      seq();
      check32("j_target_pc", bus.pc_d, 32'h3040);

      // Misaligned jr rejected, then legal jr accepted with error sticky
      step(1, 0, 0, 2'b11, '0, '0, 32'h3042);
      check32("jr_bad_err", 32'(bus.addr_err), 32'd1);
      check32("jr_bad_PC", bus.PC, 32'h3044);
      check32("jr_bad_valid", 32'(bus.valid_d), 32'd0);
      seq();
      step(1, 0, 0, 2'b11, '0, '0, 32'h3100);
      check32("jr_ok_PC", bus.PC, 32'h3100);
      check32("jr_ok_err", 32'(bus.addr_err), 32'd1);

      // Stall with flush
      step(1, 1, 1, 2'b01, 32'h3200, '0, '0);
      check32("sf_PC", bus.PC, 32'h3100);
      check32("sf_instr", bus.instr_d, 32'h0);

      // Run off the end of IM, then reset mid-run
      step(0, 0, 0, 2'b00, '0, '0, '0);
      seq();
      step(1, 0, 0, 2'b11, '0, '0, 32'h3FFC);
      check32("end_PC", bus.PC, 32'h3FFC);
      seq();
      check32("end_err", 32'(bus.addr_err), 32'd1);
      check32("end_PC_held", bus.PC, 32'h3FFC);
      seq();
      step(0, 1, 0, 2'b11, '0, '0, 32'h3000);
      check32("mid_rst_PC", bus.PC, 32'h3000);
      check32("mid_rst_cnt", bus.fetch_cnt, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) >= 2),
              ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 99) < 10),
              2'($urandom_range(0, 3)),
              rand_target(),
              26'($urandom_range(32'hB00, 32'h1100)),
              rand_target());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
